seq_signed_divider: RTL and testbench

//  Iterative signed integer divider; the inverse operation to the Booth multiplier datapath.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_restore_step.sv | 38 +++
 rtl/seq_signed_divider.sv | 213 +++++++++++++++++++++
 tb/tb_seq_signed_divider.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
//   div_state_e        : divider FSM states (IDLE, CALC, FIXUP, DONE)
//   DIV_WIDTH_DEFAULT  : default operand/result width
//   cnt_w()            : width of the bit-position counter for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 8;

  // Counter must hold WIDTH-1 down to 0.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational step of restoring division on unsigned magnitudes.
// Ports:
//   rem_in       [WIDTH:0]   partial remainder before this step
//   divisor_mag  [WIDTH-1:0] divisor magnitude
//   dividend_bit             next dividend bit, MSB first
//   rem_out      [WIDTH:0]   partial remainder after this step
//   qbit                     quotient bit produced by this step
module div_restore_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor_mag,
  input  logic             dividend_bit,
  output logic [WIDTH:0]   rem_out,
  output logic             qbit
);

  // One extra bit so the shifted value never loses its MSB before the compare.
  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] diff_s;

  assign shifted_s = {rem_in, dividend_bit};
  assign diff_s    = shifted_s - {2'b00, divisor_mag};

  // Subtract the divisor only when it fits; otherwise keep the shifted remainder.
  always_comb begin
    rem_out = shifted_s[WIDTH:0];
    qbit    = 1'b0;
    if (shifted_s >= {2'b00, divisor_mag}) begin
      rem_out = diff_s[WIDTH:0];
      qbit    = 1'b1;
    end else begin
      rem_out = shifted_s[WIDTH:0];
      qbit    = 1'b0;
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed integer divider: one quotient bit per clock using restoring
// division on operand magnitudes, then a single sign-fixup cycle.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
// Divide by zero returns quotient = all ones, remainder = dividend.
// Optional feature macro: DIV_BY_ZERO_FLAG_EN
//   defined     -> div_by_zero port present; a zero divisor bypasses CALC
//   not defined -> no div_by_zero port; a zero divisor runs the full iteration
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   dividend, divisor     signed operands, latched at accept
//   out_valid / out_ready result handshake, results held until accepted
//   quotient, remainder   signed results
//   div_by_zero           zero-divisor flag, valid with out_valid (feature build)
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_BY_ZERO_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int CW = cnt_w(WIDTH);

  // Two's complement magnitude; |-2^(W-1)| = 2^(W-1) still fits as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  div_state_e       state_r;
  div_state_e       state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_mag_r;
  logic [WIDTH-1:0] b_mag_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] q_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             out_valid_r;
  logic [WIDTH:0]   rem_step_s;
  logic             qbit_s;
  logic             accept_s;
  logic             zero_div_s;

`ifdef DIV_BY_ZERO_FLAG_EN
  logic             dbz_r;
  logic             div_by_zero_r;
`endif

  assign in_ready   = (state_r == IDLE);
  assign accept_s   = in_valid && (state_r == IDLE);
  assign zero_div_s = (divisor == {WIDTH{1'b0}});

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in       (rem_r),
    .divisor_mag  (b_mag_r),
    .dividend_bit (a_mag_r[cnt_r]),
    .rem_out      (rem_step_s),
    .qbit         (qbit_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
`ifdef DIV_BY_ZERO_FLAG_EN
          if (zero_div_s) begin
            state_s = FIXUP;
          end else begin
            state_s = CALC;
          end
`else
          state_s = CALC;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CW'(0)) begin
          state_s = FIXUP;
        end else begin
          state_s = CALC;
        end
      end
      FIXUP: begin
        state_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, iteration, sign fixup and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= CW'(0);
      a_mag_r     <= {WIDTH{1'b0}};
      b_mag_r     <= {WIDTH{1'b0}};
      rem_r       <= {(WIDTH+1){1'b0}};
      q_r         <= {WIDTH{1'b0}};
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
`ifdef DIV_BY_ZERO_FLAG_EN
      dbz_r         <= 1'b0;
      div_by_zero_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_mag_r <= mag(dividend);
            b_mag_r <= mag(divisor);
            // A zero divisor keeps the all-ones quotient unsigned regardless of
            // the dividend sign; only the remainder follows the dividend.
            neg_q_r <= (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && !zero_div_s;
            neg_r_r <= dividend[WIDTH-1];
            cnt_r   <= CW'(WIDTH-1);
`ifdef DIV_BY_ZERO_FLAG_EN
            dbz_r <= zero_div_s;
            if (zero_div_s) begin
              q_r   <= {WIDTH{1'b1}};
              rem_r <= {1'b0, mag(dividend)};
            end else begin
              q_r   <= {WIDTH{1'b0}};
              rem_r <= {(WIDTH+1){1'b0}};
            end
`else
            q_r   <= {WIDTH{1'b0}};
            rem_r <= {(WIDTH+1){1'b0}};
`endif
          end else begin
            cnt_r <= cnt_r;
          end
        end
        CALC: begin
          rem_r        <= rem_step_s;
          q_r[cnt_r]   <= qbit_s;
          if (cnt_r != CW'(0)) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        FIXUP: begin
          quotient_r  <= neg_q_r ? (~q_r + WIDTH'(1)) : q_r;
          remainder_r <= neg_r_r ? (~rem_r[WIDTH-1:0] + WIDTH'(1)) : rem_r[WIDTH-1:0];
          out_valid_r <= 1'b1;
`ifdef DIV_BY_ZERO_FLAG_EN
          div_by_zero_r <= dbz_r;
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
`ifdef DIV_BY_ZERO_FLAG_EN
  assign div_by_zero = div_by_zero_r;
`endif

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider (WIDTH=8): directed cases,
// backpressure, mid-operation reset and a randomized sweep against a
// plain-arithmetic reference model.
module tb_seq_signed_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic         div_by_zero;
`endif

  int errors = 0;
  int checks = 0;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_BY_ZERO_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: C-style truncating division; zero divisor gives -1 / dividend.
  function automatic logic [15:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int ai;
    int bi;
    logic [W-1:0] q;
    logic [W-1:0] r;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      q = 8'hFF;
      r = a;
    end else begin
      q = 8'(ai / bi);
      r = 8'(ai % bi);
    end
    return {q, r};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
`ifdef DIV_BY_ZERO_FLAG_EN
    if (b == 8'h00) return 2;
`endif
    return W + 2;
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) check_val("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Cycles counted from the accept cycle (index 0) to the first out_valid cycle.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    logic [15:0] exp;
    exp = ref_div(a, b);
    check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_val({tag, "_lat"}, lat, ref_lat(b));
    check_val({tag, "_q"}, {24'd0, quotient}, {24'd0, exp[15:8]});
    check_val({tag, "_r"}, {24'd0, remainder}, {24'd0, exp[7:0]});
`ifdef DIV_BY_ZERO_FLAG_EN
    check_val({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, (b == 8'h00)});
`endif
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    launch(a, b);
    wait_done(lat);
    check_result(tag, a, b, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = 8'h00;
    divisor   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_q", {24'd0, quotient}, 32'd0);
    check_val("rst_r", {24'd0, remainder}, 32'd0);
    rst_n = 1'b1;

    run_op("p100_p7", 8'd100, 8'd7);
    run_op("n100_p7", 8'h9C, 8'd7);
    run_op("p100_n7", 8'd100, 8'hF9);
    run_op("n100_n7", 8'h9C, 8'hF9);
    run_op("n128_n1", 8'h80, 8'hFF);
    run_op("n128_p1", 8'h80, 8'h01);
    run_op("p5_z", 8'd5, 8'h00);
    run_op("n5_z", 8'hFB, 8'h00);
    run_op("n128_z", 8'h80, 8'h00);
    run_op("p127_n128", 8'h7F, 8'h80);

    // Backpressure: result held, no new accept while DONE.
    out_ready = 1'b0;
    launch(8'd100, 8'd7);
    wait_done(lat);
    check_result("bp", 8'd100, 8'd7, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk); #1;
      check_val("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("bp_hold_q", {24'd0, quotient}, 32'd14);
      check_val("bp_hold_r", {24'd0, remainder}, 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("bp_release_valid", {31'd0, out_valid}, 32'd0);
    run_op("b2b_7_2", 8'd7, 8'd2);

    // Reset during the 4th CALC cycle aborts the operation.
    launch(8'd100, 8'd7);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("mid_rst_q", {24'd0, quotient}, 32'd0);
    check_val("mid_rst_r", {24'd0, remainder}, 32'd0);
    run_op("post_rst", 8'h9C, 8'd7);

    // Randomized signed sweep, with some forced zero and extreme divisors.
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ((i % 25) == 0) rb = 8'h00;
      if ((i % 37) == 0) rb = 8'hFF;
      if ((i % 41) == 0) ra = 8'h80;
      run_op("rand", ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
